// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the single register-file write port between NREQ writeback sources.
// At most one requester is granted per cycle. The grant (req_ready) is
// combinational. The resulting write enable, address and data reach the
// register file one cycle later through registers.
//
// Arbitration is round-robin by default: the search starts at a pointer and
// wraps modulo NREQ. After every accepted transfer the pointer moves to just
// past the winner.
//
// Optional build macro: REGARB_FIXED_PRIO_EN
//   defined   -> fixed priority; the lowest valid index wins and there is no pointer
//   undefined -> round-robin
//
// A write to address 0 is accepted like any other write, but it never raises
// wr_en. Register 0 is hard-wired.

module regfile_wr_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [2:0]               last_grant,
  output logic                     busy
);

  // Arbitration result.
  logic [NREQ-1:0]   grant_s;
  logic [2:0]        grant_idx_s;
  logic              grant_any_s;
  logic              search_en_s;

  // Payload of the winning requester.
  logic [ADDR_W-1:0] addr_sel_s;
  logic [DATA_W-1:0] data_sel_s;

  // Write-port registers.
  logic              wr_en_q,      wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,    wr_data_d;
  logic [2:0]        last_grant_q, last_grant_d;

`ifndef REGARB_FIXED_PRIO_EN
  // Round-robin pointer: the index where the next search begins.
  logic [2:0]        ptr_q, ptr_d;
`endif

  // No grant can be given while in reset or while hold is high.
  assign search_en_s = ~reset & ~hold;

  // Grant search. Walk the candidates in priority order and take the first
  // valid one. The result depends only on valid, hold, reset and the pointer.
  always_comb begin
    int  cand;
    int  raw;
    logic hit;
    grant_s     = {NREQ{1'b0}};
    grant_idx_s = 3'd0;
    grant_any_s = 1'b0;
    cand        = 0;
    raw         = 0;
    hit         = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef REGARB_FIXED_PRIO_EN
      raw  = k;
`else
      raw  = int'(ptr_q) + k;
`endif
      cand = (raw >= NREQ) ? (raw - NREQ) : raw;
      for (int j = 0; j < NREQ; j++) begin
        hit         = search_en_s & ~grant_any_s & (j == cand) & req_valid[j];
        grant_s[j]  = grant_s[j] | hit;
        grant_idx_s = hit ? 3'(j) : grant_idx_s;
        grant_any_s = grant_any_s | hit;
      end
    end
  end

  // Select the address and data of the granted requester. The grant is
  // one-hot, so at most one slice is ever picked.
  always_comb begin
    addr_sel_s = {ADDR_W{1'b0}};
    data_sel_s = {DATA_W{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      addr_sel_s = grant_s[j] ? req_addr[j*ADDR_W +: ADDR_W] : addr_sel_s;
      data_sel_s = grant_s[j] ? req_data[j*DATA_W +: DATA_W] : data_sel_s;
    end
  end

  // Next state of the write port. The address and data registers keep
  // their values on idle cycles, and a write to register 0 is swallowed.
  always_comb begin
    wr_en_d      = grant_any_s & (addr_sel_s != {ADDR_W{1'b0}});
    wr_addr_d    = grant_any_s ? addr_sel_s  : wr_addr_q;
    wr_data_d    = grant_any_s ? data_sel_s  : wr_data_q;
    last_grant_d = grant_any_s ? grant_idx_s : last_grant_q;
  end

`ifndef REGARB_FIXED_PRIO_EN
  // Next pointer. After a transfer, move just past the winner (wrapping).
  // Otherwise the pointer holds, which also freezes it during hold.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any_s) begin
      ptr_d = (grant_idx_s == 3'(NREQ - 1)) ? 3'd0 : (grant_idx_s + 3'd1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, with synchronous reset to index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Write-port registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= {DATA_W{1'b0}};
      last_grant_q <= 3'd0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req_ready  = grant_s;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign last_grant = last_grant_q;
  assign busy       = (|req_valid) & ~hold;

  regfile_wr_arbiter_chk #(
    .NREQ (NREQ)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .req_valid (req_valid),
    .req_ready (req_ready)
  );

endmodule

// Protocol properties of the grant vector.
module regfile_wr_arbiter_chk #(
  parameter int NREQ = 3
) (
  input logic            clk,
  input logic            reset,
  input logic            hold,
  input logic [NREQ-1:0] req_valid,
  input logic [NREQ-1:0] req_ready
);

  a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));

  a_ready_blocked : assert property (@(posedge clk)
    (reset || hold) |-> (req_ready == {NREQ{1'b0}}));

  a_ready_needs_valid : assert property (@(posedge clk)
    ((req_ready & ~req_valid) == {NREQ{1'b0}}));

endmodule
